fetch_sequencer: RTL

//  Multi-cycle fetch/next-PC controller for the RV32I core. Owns the PC, requests

---
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch / next-PC controller for the RV32I core. It owns the PC, fetches over an
// imem req/ack handshake and selects the next PC once the held instruction leaves EXEC.
//
// state | meaning
// IDLE  | one cycle after reset, before the first fetch
// FETCH | imem_req high at pc; waits for imem_ack or a timeout
// EXEC  | instr valid for the datapath; holds while stall is high
// HALT  | terminal stop (SYSTEM, misaligned target, imem timeout); only rst leaves
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] sb_target,
   input  logic [31:0] uj_target,
   input  logic [31:0] jalr_target,
   output logic [31:0] retire_cnt,
   output logic        halted,
   output logic [1:0]  err
);

   localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CTR_LAST = CW'(TIMEOUT - 1);

   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_MISALGN = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] ctr;
   logic [31:0]   npc;
   logic          is_sys;
   logic          misal;
   logic          ctr_done;
   logic          unused_bits;

   assign unused_bits = ^{jalr_target[0], instr[31:7]};
   assign ctr_done    = (ctr == CTR_LAST);
   assign misal       = (npc[1:0] != 2'b00);
   assign imem_addr   = pc;

   always_comb begin
      npc    = pc + 32'd4;
      is_sys = 1'b0;
      case (instr[6:0])
         OP_SYSTEM: is_sys = 1'b1;
         OP_JAL:    npc    = uj_target;
         OP_JALR:   npc    = {jalr_target[31:1], 1'b0};
         OP_BRANCH: if (br_taken) npc = sb_target;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            if (imem_ack)      state_nxt = EXEC;
            else if (ctr_done) state_nxt = HALT;
         end
         EXEC: begin
            if (!stall) state_nxt = (is_sys || misal) ? HALT : FETCH;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state == FETCH);
      instr_valid = (state == EXEC);
      halted      = (state == HALT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         instr      <= 32'd0;
         retire_cnt <= 32'd0;
         err        <= ERR_NONE;
         ctr        <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  instr <= imem_rdata;
                  ctr   <= '0;
               end else if (ctr_done) begin
                  err <= ERR_TIMEOUT;
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end
            EXEC: begin
               // SYSTEM retires but leaves pc; a misaligned target neither moves nor retires
               if (!stall) begin
                  if (is_sys) begin
                     retire_cnt <= retire_cnt + 32'd1;
                     err        <= ERR_NONE;
                  end else if (misal) begin
                     err <= ERR_MISALGN;
                  end else begin
                     pc         <= npc;
                     retire_cnt <= retire_cnt + 32'd1;
                  end
               end
            end
            default: ctr <= '0;
         endcase
      end
   end

endmodule
